// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debouncer: default stability window and key levels.
// Keys are active-low, so the released level is 1.
package key_debounce_pkg;
  localparam int   STABLE_CYCLES_DEF = 10;
  localparam logic KEY_PRESSED       = 1'b0;
  localparam logic KEY_RELEASED      = 1'b1;
endpackage

// File: rtl/debounce_channel.sv
// Single-key debouncer: 2-flop sync, stability counter, debounced state, press pulse.
// Pulse appears STABLE_CYCLES+3 clocks after a clean edge; no backpressure, output is a strobe.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             prev;
  logic             deb;
  logic [CNT_W-1:0] cnt;
  logic             change;
  logic             accept;

  assign change = (s2 != prev);
  assign accept = !change && (cnt == CNT_ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= KEY_RELEASED;
      s2        <= KEY_RELEASED;
      prev      <= KEY_RELEASED;
      deb       <= KEY_RELEASED;
      cnt       <= '0;
      key_pulse <= 1'b0;
    end else begin
      s1   <= key;
      s2   <= s1;
      prev <= s2;
      // Saturating counter: acceptance fires once per stable run, never on wrap.
      if (change)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
      if (accept)
        deb <= s2;
      key_pulse <= accept && (deb == KEY_RELEASED) && (s2 == KEY_PRESSED);
    end
  end

endmodule

// File: rtl/key_debounce.sv
// N-channel active-low push-button debouncer emitting one-clock press pulses.
// Latency STABLE_CYCLES+3 clocks from a clean edge; no backpressure, pulses are strobes.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N             = 5,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_pulse
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key      (key[g]),
      .key_pulse(key_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a run-length reference model.
module tb_key_debounce;

  localparam int N = 5;
  localparam int S = 10;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key;
  logic [N-1:0] key_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  key_debounce #(.N(N), .STABLE_CYCLES(S), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .key_pulse(key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the raw key has been sampled at
  // the same value on S+1 consecutive clocks; the sync pipeline adds two clocks.
  int           run  [N];
  logic         last [N];
  logic         mdeb [N];
  logic [N-1:0] pipe0   = '0;
  logic [N-1:0] pipe1   = '0;
  logic [N-1:0] exp_now = '0;
  int           pcnt [N];

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] np;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        run[i]  = 0;
        last[i] = 1'b1;
        mdeb[i] = 1'b1;
      end
      pipe0   = '0;
      pipe1   = '0;
      exp_now = '0;
    end else begin
      np = '0;
      for (int i = 0; i < N; i++) begin
        if (key[i] == last[i]) begin
          if (run[i] < 100000) run[i]++;
        end else begin
          last[i] = key[i];
          run[i]  = 1;
        end
        if (run[i] == S + 1 && last[i] != mdeb[i]) begin
          mdeb[i] = last[i];
          if (last[i] == 1'b0) np[i] = 1'b1;
        end
      end
      exp_now = pipe1;
      pipe1   = pipe0;
      pipe0   = np;
    end
  end

  initial for (int i = 0; i < N; i++) pcnt[i] = 0;

  always @(negedge clk) begin
    chk("pulse_vs_model", 32'(key_pulse), 32'(exp_now));
    for (int i = 0; i < N; i++) pcnt[i] += int'(key_pulse[i]);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive point: 2 time units after a falling edge, well away from rising edges.
  task automatic drive_slot();
    @(negedge clk);
    #2;
  endtask

  task automatic measure(input int ch, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (key_pulse[ch]) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int c0;
  int c1;
  int tot0;
  int tot1;

  initial begin
    key   = '1;
    rst_n = 1'b0;
    cycles(3);
    #2 rst_n = 1'b1;

    // Idle after reset
    tot0 = 0;
    for (int i = 0; i < N; i++) tot0 += pcnt[i];
    cycles(100);
    tot1 = 0;
    for (int i = 0; i < N; i++) tot1 += pcnt[i];
    chk("idle_pulses", 32'(tot1 - tot0), 0);

    // Clean press on key[4]
    c0 = pcnt[4];
    drive_slot();
    key[4] = 1'b0;
    measure(4, lat);
    chk("clean_lat_in_12_14", 32'(lat >= 12 && lat <= 14), 1);
    cycles(100);
    chk("clean_pulse_count", 32'(pcnt[4] - c0), 1);
    drive_slot();
    key[4] = 1'b1;
    cycles(30);

    // Bouncy press: 5 transitions at 1.5-clock spacing, ending low
    c0 = pcnt[4];
    drive_slot();
    key[4] = 1'b0;
    repeat (4) #15 key[4] = ~key[4];
    measure(4, lat);
    chk("bounce_lat_in_12_14", 32'(lat >= 12 && lat <= 14), 1);
    cycles(100);
    chk("bounce_pulse_count", 32'(pcnt[4] - c0), 1);

    // Bouncy release, ending high: no pulse
    c0 = pcnt[4];
    drive_slot();
    key[4] = 1'b1;
    repeat (4) #15 key[4] = ~key[4];
    cycles(100);
    chk("bounce_release_count", 32'(pcnt[4] - c0), 0);

    // Second bouncy press after the confirmed release
    c0 = pcnt[4];
    drive_slot();
    key[4] = 1'b0;
    repeat (4) #15 key[4] = ~key[4];
    cycles(100);
    chk("second_press_count", 32'(pcnt[4] - c0), 1);
    drive_slot();
    key[4] = 1'b1;
    cycles(30);

    // Simultaneous presses on key[0] and key[2]
    drive_slot();
    key[0] = 1'b0;
    key[2] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (key_pulse != '0) begin
        lat = i;
        break;
      end
    end
    chk("multi_seen", 32'(lat > 0), 1);
    chk("multi_pulse", 32'(key_pulse), 32'h05);
    @(posedge clk);
    #1;
    chk("multi_width", 32'(key_pulse), 0);
    drive_slot();
    key = '1;
    cycles(30);

    // Staggered presses on key[1] and key[3]
    c0 = pcnt[1];
    c1 = pcnt[3];
    drive_slot();
    key[1] = 1'b0;
    cycles(3);
    drive_slot();
    key[3] = 1'b0;
    cycles(50);
    chk("stagger_k1_count", 32'(pcnt[1] - c0), 1);
    chk("stagger_k3_count", 32'(pcnt[3] - c1), 1);
    drive_slot();
    key = '1;
    cycles(30);

    // Async reset five clocks into a stable press; key still held at release
    c0 = pcnt[4];
    drive_slot();
    key[4] = 1'b0;
    cycles(5);
    #3 rst_n = 1'b0;
    #1 chk("rst_async_drop", 32'(key_pulse), 0);
    cycles(3);
    #2 rst_n = 1'b1;
    chk("rst_no_pulse", 32'(pcnt[4] - c0), 0);
    measure(4, lat);
    chk("rst_release_lat", 32'(lat), 32'(S + 3));
    cycles(50);
    chk("rst_pulse_count", 32'(pcnt[4] - c0), 1);
    drive_slot();
    key = '1;
    cycles(30);

    // Random bouncing on all channels, checked cycle by cycle against the model
    repeat (600) begin
      drive_slot();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) key[i] = ~key[i];
    end
    drive_slot();
    key = '1;
    cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
